// File: rtl/tiled_controller_fsm.sv
// Tiled convolution layer controller.
// Walks output channel tiles, then rows, then columns. Each tile starts with a
// kernel load; each pixel is an input load followed by a fixed-length compute
// burst. Finished pixel tags travel through a PIPE_DELAY-deep pipeline that
// matches the datapath latency, and the layer ends once that pipeline drains.
module tiled_controller_fsm #(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int CH_PAR             = 6,
  parameter int KERNEL_BEATS       = 12,
  parameter int INPUT_BEATS        = 4,
  parameter int COMPUTE_CYCLES     = 6,
  parameter int PIPE_DELAY         = 2
) (
  input  logic                              clk,
  input  logic                              arst_n_in,
  input  logic                              start,
  output logic                              running,
  input  logic                              con_valid,
  output logic                              con_ready,
  output logic                              ctrl_kernel_we,
  output logic [$clog2(CH_PAR)-1:0]         ctrl_kernel_ch,
  output logic [$clog2(KERNEL_BEATS)-1:0]   ctrl_kernel_beat,
  output logic                              ctrl_input_we,
  output logic [$clog2(INPUT_BEATS)-1:0]    ctrl_input_beat,
  output logic                              ctrl_mac_en,
  output logic                              ctrl_acc_clear,
  output logic [$clog2(COMPUTE_CYCLES)-1:0] ctrl_compute_step,
  output logic                              output_valid,
  output logic [31:0]                       output_x,
  output logic [31:0]                       output_y,
  output logic [31:0]                       output_ch,
  output logic                              done
);

  localparam int KCH_W   = $clog2(CH_PAR);
  localparam int KB_W    = $clog2(KERNEL_BEATS);
  localparam int IB_W    = $clog2(INPUT_BEATS);
  localparam int CS_W    = $clog2(COMPUTE_CYCLES);
  localparam int NTILES  = OUTPUT_NB_CHANNELS / CH_PAR;
  localparam int TILE_W  = (NTILES > 1) ? $clog2(NTILES) : 1;

  localparam logic [KCH_W-1:0]  KCH_LAST  = KCH_W'(CH_PAR - 1);
  localparam logic [KB_W-1:0]   KB_LAST   = KB_W'(KERNEL_BEATS - 1);
  localparam logic [IB_W-1:0]   IB_LAST   = IB_W'(INPUT_BEATS - 1);
  localparam logic [CS_W-1:0]   CS_LAST   = CS_W'(COMPUTE_CYCLES - 1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NTILES - 1);
  localparam logic [31:0]       X_LAST    = 32'(FEATURE_MAP_WIDTH - 1);
  localparam logic [31:0]       Y_LAST    = 32'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [31:0]       CH_STEP   = 32'(CH_PAR);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    LOAD_I,
    COMPUTE,
    DRAIN
  } state_t;

  state_t              state;
  logic [KCH_W-1:0]    kch_cnt;
  logic [KB_W-1:0]     kbeat_cnt;
  logic [IB_W-1:0]     ibeat_cnt;
  logic [CS_W-1:0]     step_cnt;
  logic [TILE_W-1:0]   tile_cnt;
  logic [31:0]         x_cnt;
  logic [31:0]         y_cnt;

  logic                    tag_push;
  logic [31:0]             tag_ch;
  logic [PIPE_DELAY-1:0]   pipe_v;
  logic [31:0]             pipe_x  [PIPE_DELAY];
  logic [31:0]             pipe_y  [PIPE_DELAY];
  logic [31:0]             pipe_ch [PIPE_DELAY];
  logic                    pipe_busy;

  assign tag_push  = (state == COMPUTE) && (step_cnt == CS_LAST);
  assign tag_ch    = 32'(tile_cnt) * CH_STEP;
  assign pipe_busy = |pipe_v;

  // Layer sequencing: state plus all loop counters.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state     <= IDLE;
      kch_cnt   <= '0;
      kbeat_cnt <= '0;
      ibeat_cnt <= '0;
      step_cnt  <= '0;
      tile_cnt  <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD_K;
            kch_cnt   <= '0;
            kbeat_cnt <= '0;
            ibeat_cnt <= '0;
            step_cnt  <= '0;
            tile_cnt  <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
          end
        end
        LOAD_K: begin
          if (con_valid) begin
            if (kbeat_cnt == KB_LAST) begin
              kbeat_cnt <= '0;
              if (kch_cnt == KCH_LAST) begin
                kch_cnt <= '0;
                state   <= LOAD_I;
              end else begin
                kch_cnt <= kch_cnt + 1'b1;
              end
            end else begin
              kbeat_cnt <= kbeat_cnt + 1'b1;
            end
          end
        end
        LOAD_I: begin
          if (con_valid) begin
            if (ibeat_cnt == IB_LAST) begin
              ibeat_cnt <= '0;
              step_cnt  <= '0;
              state     <= COMPUTE;
            end else begin
              ibeat_cnt <= ibeat_cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (step_cnt == CS_LAST) begin
            step_cnt <= '0;
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              if (y_cnt == Y_LAST) begin
                y_cnt <= '0;
                if (tile_cnt == TILE_LAST) begin
                  tile_cnt <= '0;
                  state    <= DRAIN;
                end else begin
                  tile_cnt <= tile_cnt + 1'b1;
                  state    <= LOAD_K;
                end
              end else begin
                y_cnt <= y_cnt + 32'd1;
                state <= LOAD_I;
              end
            end else begin
              x_cnt <= x_cnt + 32'd1;
              state <= LOAD_I;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!pipe_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // First tag stage captures the pixel finishing its last compute cycle.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      pipe_v[0]  <= 1'b0;
      pipe_x[0]  <= '0;
      pipe_y[0]  <= '0;
      pipe_ch[0] <= '0;
    end else begin
      pipe_v[0] <= tag_push;
      if (tag_push) begin
        pipe_x[0]  <= x_cnt;
        pipe_y[0]  <= y_cnt;
        pipe_ch[0] <= tag_ch;
      end
    end
  end

  for (genvar g = 1; g < PIPE_DELAY; g++) begin : g_pipe
    // Remaining tag stages shift unconditionally to match datapath latency.
    always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
        pipe_v[g]  <= 1'b0;
        pipe_x[g]  <= '0;
        pipe_y[g]  <= '0;
        pipe_ch[g] <= '0;
      end else begin
        pipe_v[g]  <= pipe_v[g-1];
        pipe_x[g]  <= pipe_x[g-1];
        pipe_y[g]  <= pipe_y[g-1];
        pipe_ch[g] <= pipe_ch[g-1];
      end
    end
  end

  assign output_valid = pipe_v[PIPE_DELAY-1];
  assign output_x     = pipe_x[PIPE_DELAY-1];
  assign output_y     = pipe_y[PIPE_DELAY-1];
  assign output_ch    = pipe_ch[PIPE_DELAY-1];

  // Datapath controls decoded from state and counters; zero outside owning state.
  always_comb begin
    running           = (state != IDLE);
    con_ready         = 1'b0;
    ctrl_kernel_we    = 1'b0;
    ctrl_kernel_ch    = '0;
    ctrl_kernel_beat  = '0;
    ctrl_input_we     = 1'b0;
    ctrl_input_beat   = '0;
    ctrl_mac_en       = 1'b0;
    ctrl_acc_clear    = 1'b0;
    ctrl_compute_step = '0;
    done              = 1'b0;
    case (state)
      LOAD_K: begin
        con_ready        = 1'b1;
        ctrl_kernel_we   = con_valid;
        ctrl_kernel_ch   = kch_cnt;
        ctrl_kernel_beat = kbeat_cnt;
      end
      LOAD_I: begin
        con_ready       = 1'b1;
        ctrl_input_we   = con_valid;
        ctrl_input_beat = ibeat_cnt;
      end
      COMPUTE: begin
        ctrl_mac_en       = 1'b1;
        ctrl_acc_clear    = (step_cnt == '0);
        ctrl_compute_step = step_cnt;
      end
      DRAIN: begin
        done = !pipe_busy;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tiled_controller_fsm.sv
// Directed bench for tiled_controller_fsm: a small configuration checked
// cycle by cycle against hand-derived schedules, plus a default-parameter
// instance checked for tag channel values and kernel channel coverage.
module tb_tiled_controller_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n_in, start, con_valid, start_b;

  // Small instance: W=2 H=2 OCH=4 CH_PAR=2 KB=3 IB=2 CC=3 PD=2
  logic        running, con_ready, kwe, iwe, mac, clr, ov, done;
  logic [0:0]  kch;
  logic [1:0]  kbeat;
  logic [0:0]  ibeat;
  logic [1:0]  step;
  logic [31:0] ox, oy, och;

  tiled_controller_fsm #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(4),
    .CH_PAR(2), .KERNEL_BEATS(3), .INPUT_BEATS(2), .COMPUTE_CYCLES(3), .PIPE_DELAY(2)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running),
    .con_valid(con_valid), .con_ready(con_ready),
    .ctrl_kernel_we(kwe), .ctrl_kernel_ch(kch), .ctrl_kernel_beat(kbeat),
    .ctrl_input_we(iwe), .ctrl_input_beat(ibeat),
    .ctrl_mac_en(mac), .ctrl_acc_clear(clr), .ctrl_compute_step(step),
    .output_valid(ov), .output_x(ox), .output_y(oy), .output_ch(och), .done(done)
  );

  // Default instance with 4x4 map and 12 output channels
  logic        run_b, rdy_b, kwe_b, iwe_b, mac_b, clr_b, ov_b, done_b;
  logic [2:0]  kch_b;
  logic [3:0]  kbeat_b;
  logic [1:0]  ibeat_b;
  logic [2:0]  step_b;
  logic [31:0] ox_b, oy_b, och_b;

  tiled_controller_fsm #(
    .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4), .OUTPUT_NB_CHANNELS(12)
  ) dut_b (
    .clk(clk), .arst_n_in(arst_n_in), .start(start_b), .running(run_b),
    .con_valid(1'b1), .con_ready(rdy_b),
    .ctrl_kernel_we(kwe_b), .ctrl_kernel_ch(kch_b), .ctrl_kernel_beat(kbeat_b),
    .ctrl_input_we(iwe_b), .ctrl_input_beat(ibeat_b),
    .ctrl_mac_en(mac_b), .ctrl_acc_clear(clr_b), .ctrl_compute_step(step_b),
    .output_valid(ov_b), .output_x(ox_b), .output_y(oy_b), .output_ch(och_b), .done(done_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int x; int y; int ch; } ov_t;
  ov_t  ov_q[$];
  int   done_cyc;
  bit   logging = 0;
  int   mon_rel;
  logic tr_run [256];
  logic tr_rdy [256];
  logic tr_kwe [256];
  logic tr_iwe [256];
  logic tr_mac [256];
  logic tr_clr [256];
  int   tr_kch [256];
  int   tr_kbeat [256];
  int   tr_ibeat [256];
  int   tr_step [256];

  // Per-cycle trace of the small instance, relative to the start cycle.
  always @(negedge clk) begin
    if (logging) begin
      mon_rel = cyc - base;
      if (mon_rel >= 0 && mon_rel < 256) begin
        tr_run[mon_rel]   = running;
        tr_rdy[mon_rel]   = con_ready;
        tr_kwe[mon_rel]   = kwe;
        tr_iwe[mon_rel]   = iwe;
        tr_mac[mon_rel]   = mac;
        tr_clr[mon_rel]   = clr;
        tr_kch[mon_rel]   = int'(kch);
        tr_kbeat[mon_rel] = int'(kbeat);
        tr_ibeat[mon_rel] = int'(ibeat);
        tr_step[mon_rel]  = int'(step);
      end
      if (ov) ov_q.push_back('{mon_rel, int'(ox), int'(oy), int'(och)});
      if (done && done_cyc < 0) done_cyc = mon_rel;
    end
  end

  // One layer on the small instance; stall/extra start/reset windows in relative cycles.
  task automatic run_layer(input int stall_lo, input int stall_hi, input int xstart,
                           input int rst_lo, input int rst_hi, input int max_cyc);
    for (int i = 0; i < 256; i++) begin
      tr_run[i] = 1'b0; tr_rdy[i] = 1'b0; tr_kwe[i] = 1'b0; tr_iwe[i] = 1'b0;
      tr_mac[i] = 1'b0; tr_clr[i] = 1'b0; tr_kch[i] = 0; tr_kbeat[i] = 0;
      tr_ibeat[i] = 0; tr_step[i] = 0;
    end
    ov_q.delete();
    done_cyc = -1;
    @(posedge clk); #1;
    base = cyc; logging = 1; start = 1'b1; con_valid = 1'b1;
    for (int r = 1; r <= max_cyc; r++) begin
      @(posedge clk); #1;
      start     = (r == xstart);
      con_valid = !(r >= stall_lo && r <= stall_hi);
      arst_n_in = !(r >= rst_lo && r <= rst_hi);
      if (done_cyc >= 0 && r > done_cyc + 1) break;
    end
    @(negedge clk);
    logging = 0; start = 1'b0; con_valid = 1'b1; arst_n_in = 1'b1;
  endtask

  // Expected tag order and output cycle for the small configuration.
  task automatic check_tags(input string tag, input int shift);
    int k;
    check_eq({tag, "_count"}, ov_q.size(), 8);
    k = 0;
    for (int t = 0; t < 2; t++)
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 2; x++) begin
          if (k < ov_q.size()) begin
            check_eq($sformatf("%s_cyc%0d", tag, k), ov_q[k].c, 13 + 26 * t + 5 * (2 * y + x) + shift);
            check_eq($sformatf("%s_x%0d", tag, k), ov_q[k].x, x);
            check_eq($sformatf("%s_y%0d", tag, k), ov_q[k].y, y);
            check_eq($sformatf("%s_ch%0d", tag, k), ov_q[k].ch, 2 * t);
          end
          k++;
        end
  endtask

  // Default instance observers
  bit         logging_b = 0;
  int         nb_ov = 0, nb_badch = 0, nb_ch6 = 0, nb_kw = 0, nb_done = 0;
  logic [5:0] kmask [2];

  always @(negedge clk) begin
    if (logging_b) begin
      if (ov_b) begin
        nb_ov++;
        if (och_b != 32'd0 && och_b != 32'd6) nb_badch++;
        if (och_b == 32'd6) nb_ch6++;
      end
      if (kwe_b) begin
        if (nb_kw < 144 && kch_b < 3'd6) kmask[nb_kw / 72][kch_b] = 1'b1;
        nb_kw++;
      end
      if (done_b) nb_done++;
    end
  end

  initial begin
    arst_n_in = 1'b0; start = 1'b0; con_valid = 1'b0; start_b = 1'b0;
    kmask[0] = '0; kmask[1] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_running", running, 0);
    check_eq("rst_con_ready", con_ready, 0);
    check_eq("rst_output_valid", ov, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_output_x", ox, 0);
    check_eq("rst_output_ch", och, 0);
    @(posedge clk); #1 arst_n_in = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal layer, con_valid held high
    run_layer(-1, -1, -1, -1, -1, 200);
    check_eq("nom_run0", tr_run[0], 0);
    check_eq("nom_kwe1", tr_kwe[1], 1);
    check_eq("nom_rdy1", tr_rdy[1], 1);
    check_eq("nom_kch4", tr_kch[4], 1);
    check_eq("nom_kbeat6", tr_kbeat[6], 2);
    check_eq("nom_kwe7", tr_kwe[7], 0);
    check_eq("nom_iwe7", tr_iwe[7], 1);
    check_eq("nom_ibeat8", tr_ibeat[8], 1);
    check_eq("nom_mac8", tr_mac[8], 0);
    check_eq("nom_mac9", tr_mac[9], 1);
    check_eq("nom_clr9", tr_clr[9], 1);
    check_eq("nom_clr10", tr_clr[10], 0);
    check_eq("nom_step11", tr_step[11], 2);
    check_eq("nom_rdy10", tr_rdy[10], 0);
    check_eq("nom_mac12", tr_mac[12], 0);
    check_tags("nom", 0);
    check_eq("nom_done_cyc", done_cyc, 55);
    check_eq("nom_run55", tr_run[55], 1);
    check_eq("nom_run56", tr_run[56], 0);

    // Five-cycle con_valid stall inside LOAD_I of the first pixel
    run_layer(8, 12, -1, -1, -1, 200);
    check_eq("stall_ibeat8", tr_ibeat[8], 1);
    check_eq("stall_ibeat12", tr_ibeat[12], 1);
    check_eq("stall_iwe10", tr_iwe[10], 0);
    check_eq("stall_rdy10", tr_rdy[10], 1);
    check_eq("stall_iwe13", tr_iwe[13], 1);
    check_eq("stall_mac13", tr_mac[13], 0);
    check_eq("stall_clr14", tr_clr[14], 1);
    check_tags("stall", 5);
    check_eq("stall_done_cyc", done_cyc, 60);

    // start pulsed during COMPUTE must be ignored
    run_layer(-1, -1, 10, -1, -1, 200);
    check_eq("xstart_step11", tr_step[11], 2);
    check_tags("xstart", 0);
    check_eq("xstart_done_cyc", done_cyc, 55);

    // Reset during COMPUTE of pixel (1,0): only pixel (0,0) tag ever appears
    run_layer(-1, -1, -1, 15, 16, 40);
    check_eq("rst_mid_count", ov_q.size(), 1);
    check_eq("rst_mid_run15", tr_run[15], 0);
    check_eq("rst_mid_mac16", tr_mac[16], 0);
    check_eq("rst_mid_run30", tr_run[30], 0);
    check_eq("rst_mid_done", done_cyc, -1);

    // Fresh start after the mid-layer reset
    run_layer(-1, -1, -1, -1, -1, 200);
    check_tags("fresh", 0);
    check_eq("fresh_done_cyc", done_cyc, 55);

    // Default-parameter instance, 4x4 map, 12 channels
    @(posedge clk); #1;
    logging_b = 1; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int r = 0; r < 1500 && nb_done == 0; r++) @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk) logging_b = 0;
    check_eq("big_done", nb_done, 1);
    check_eq("big_ov_count", nb_ov, 32);
    check_eq("big_bad_ch", nb_badch, 0);
    check_eq("big_ch6_count", nb_ch6, 16);
    check_eq("big_kw_count", nb_kw, 144);
    check_eq("big_kmask0", 32'(kmask[0]), 32'h3F);
    check_eq("big_kmask1", 32'(kmask[1]), 32'h3F);
    check_eq("big_running_end", run_b, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
